// File: rtl/frame_buffer_writer_pkg.sv
// -----------------------------------------------------------------------------
// frame_buffer_writer_pkg
// Shared panel constants for the HUB75 frame buffer write path: panel geometry,
// RAM word address width per page, RGB565 field positions and the writer state
// encoding.
// -----------------------------------------------------------------------------
package frame_buffer_writer_pkg;

    localparam int PANEL_COLS = 64;
    localparam int PANEL_ROWS = 64;
    localparam int RAM_ADDR_W = 11;

    // RGB565 field MSB positions: {R[15:11], G[10:5], B[4:0]}
    localparam int RGB_R_MSB  = 15;
    localparam int RGB_G_MSB  = 10;
    localparam int RGB_B_MSB  = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } fbw_state_e;

endpackage

// File: rtl/frame_buffer_writer_raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Column/row position of the next pixel in a raster-ordered frame.
//   i_clk, i_rst_n : clock, async active-low reset (position 0,0)
//   i_restart      : sync load to (row 0, col 1) - the SOF pixel is written at
//                    (0,0) in the same cycle, so the next pixel lands at col 1
//   i_advance      : step one pixel; col wraps into a row increment, and the
//                    row wraps to 0 after the last pixel of the frame
//   o_col, o_row   : current position
//   o_last         : current position is the final pixel of the frame
// -----------------------------------------------------------------------------
module raster_counter #(
    parameter int COLS  = 64,
    parameter int ROWS  = 64,
    parameter int COL_W = $clog2(COLS),
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_restart,
    input  logic             i_advance,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_last
);

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;

    // Position register; restart has priority over advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (i_restart) begin
            col_r <= COL_W'(1);
            row_r <= {ROW_W{1'b0}};
        end else if (i_advance) begin
            if (col_r == COL_W'(COLS - 1)) begin
                col_r <= {COL_W{1'b0}};
                row_r <= row_r + ROW_W'(1);   // power-of-two ROWS: wraps to 0 after last row
            end else begin
                col_r <= col_r + COL_W'(1);
                row_r <= row_r;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    assign o_col  = col_r;
    assign o_row  = row_r;
    assign o_last = (col_r == COL_W'(COLS - 1)) && (row_r == ROW_W'(ROWS - 1));

endmodule

// File: rtl/frame_buffer_writer.sv
// -----------------------------------------------------------------------------
// frame_buffer_writer
// Takes a raster-ordered RGB565 stream over valid/ready and writes it into two
// half-panel frame RAM banks (bank 1 = upper rows, bank 2 = lower rows), with
// page double-buffering so the scan driver only sees completed frames.
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_pixel_data/valid/sof: pixel stream in, sof marks pixel (0,0)
//   o_pixel_ready         : low only while a finished page awaits the swap
//   o_ram_addr/data       : registered write port shared by both banks
//   o_ram_b1_we/b2_we     : one-cycle bank write strobes
//   o_write_page          : page being filled
//   o_display_page        : page the scan driver reads
//   i_display_frame_end   : scan driver frame boundary pulse
//   o_frame_done          : pulse, last pixel of a frame accepted
//   o_sof_error           : pulse, SOF seen in the middle of a frame
// -----------------------------------------------------------------------------
module frame_buffer_writer
    import frame_buffer_writer_pkg::*;
#(
    parameter int COLS   = PANEL_COLS,
    parameter int ROWS   = PANEL_ROWS,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [15:0]       i_pixel_data,
    input  logic              i_pixel_valid,
    input  logic              i_pixel_sof,
    output logic              o_pixel_ready,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [15:0]       o_ram_data,
    output logic              o_ram_b1_we,
    output logic              o_ram_b2_we,
    output logic              o_write_page,
    output logic              o_display_page,
    input  logic              i_display_frame_end,
    output logic              o_frame_done,
    output logic              o_sof_error
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    fbw_state_e        state_r;
    fbw_state_e        next_state_s;

    logic [COL_W-1:0]  col_s;
    logic [ROW_W-1:0]  row_s;
    logic              last_s;

    logic              accept_s;
    logic              do_write_s;
    logic              at_origin_s;
    logic              cnt_restart_s;
    logic              cnt_advance_s;
    logic              frame_done_s;
    logic              sof_error_s;
    logic              swap_s;
    logic [COL_W-1:0]  wr_col_s;
    logic [ROW_W-1:0]  wr_row_s;
    logic [15:0]       wr_data_s;

    logic [ADDR_W-1:0] ram_addr_r;
    logic [15:0]       ram_data_r;
    logic              b1_we_r;
    logic              b2_we_r;
    logic              write_page_r;
    logic              display_page_r;
    logic              frame_done_r;
    logic              sof_error_r;

    raster_counter #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_raster_counter (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_restart (cnt_restart_s),
        .i_advance (cnt_advance_s),
        .o_col     (col_s),
        .o_row     (row_s),
        .o_last    (last_s)
    );

    assign o_pixel_ready = (state_r != ST_WAIT_SWAP);
    assign accept_s      = i_pixel_valid & o_pixel_ready;

    // Next state and per-cycle write/counter controls.
    always_comb begin
        next_state_s  = state_r;
        do_write_s    = 1'b0;
        at_origin_s   = 1'b0;
        cnt_restart_s = 1'b0;
        cnt_advance_s = 1'b0;
        frame_done_s  = 1'b0;
        sof_error_s   = 1'b0;
        swap_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Pixels before the first SOF are discarded.
                if (accept_s && i_pixel_sof) begin
                    do_write_s    = 1'b1;
                    at_origin_s   = 1'b1;
                    cnt_restart_s = 1'b1;
                    next_state_s  = ST_WRITE;
                end else begin
                    next_state_s  = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (accept_s) begin
                    do_write_s = 1'b1;
                    if (i_pixel_sof) begin
                        // Resynchronise on the new frame start and flag it.
                        at_origin_s   = 1'b1;
                        cnt_restart_s = 1'b1;
                        sof_error_s   = 1'b1;
                        next_state_s  = ST_WRITE;
                    end else begin
                        cnt_advance_s = 1'b1;
                        if (last_s) begin
                            frame_done_s = 1'b1;
                            next_state_s = ST_WAIT_SWAP;
                        end else begin
                            next_state_s = ST_WRITE;
                        end
                    end
                end else begin
                    next_state_s = ST_WRITE;
                end
            end
            ST_WAIT_SWAP: begin
                if (i_display_frame_end) begin
                    swap_s       = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT_SWAP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    assign wr_col_s  = at_origin_s ? {COL_W{1'b0}} : col_s;
    assign wr_row_s  = at_origin_s ? {ROW_W{1'b0}} : row_s;
    assign wr_data_s = {i_pixel_data[RGB_R_MSB -: 5],
                        i_pixel_data[RGB_G_MSB -: 6],
                        i_pixel_data[RGB_B_MSB -: 5]};

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered RAM write port, status pulses and page registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ram_addr_r     <= {ADDR_W{1'b0}};
            ram_data_r     <= 16'h0000;
            b1_we_r        <= 1'b0;
            b2_we_r        <= 1'b0;
            write_page_r   <= 1'b0;
            display_page_r <= 1'b1;
            frame_done_r   <= 1'b0;
            sof_error_r    <= 1'b0;
        end else begin
            // Row MSB picks the bank; the remaining row bits form the address.
            b1_we_r      <= do_write_s & ~wr_row_s[ROW_W-1];
            b2_we_r      <= do_write_s &  wr_row_s[ROW_W-1];
            frame_done_r <= frame_done_s;
            sof_error_r  <= sof_error_s;
            if (do_write_s) begin
                ram_addr_r <= {wr_row_s[ROW_W-2:0], wr_col_s};
                ram_data_r <= wr_data_s;
            end else begin
                ram_addr_r <= ram_addr_r;
                ram_data_r <= ram_data_r;
            end
            if (swap_s) begin
                display_page_r <= write_page_r;
                write_page_r   <= ~write_page_r;
            end else begin
                display_page_r <= display_page_r;
                write_page_r   <= write_page_r;
            end
        end
    end

    assign o_ram_addr     = ram_addr_r;
    assign o_ram_data     = ram_data_r;
    assign o_ram_b1_we    = b1_we_r;
    assign o_ram_b2_we    = b2_we_r;
    assign o_write_page   = write_page_r;
    assign o_display_page = display_page_r;
    assign o_frame_done   = frame_done_r;
    assign o_sof_error    = sof_error_r;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// -----------------------------------------------------------------------------
// tb_frame_buffer_writer
// Self-checking bench for frame_buffer_writer. The reference model tracks the
// frame as a linear pixel index (0..4095): bank = index / 2048, address =
// index % 2048, plus a three-mode writer state and the two page bits.
// -----------------------------------------------------------------------------
module tb_frame_buffer_writer;

    localparam int NPIX = 4096;
    localparam int HALF = 2048;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [15:0] i_pixel_data;
    logic        i_pixel_valid;
    logic        i_pixel_sof;
    logic        o_pixel_ready;
    logic [10:0] o_ram_addr;
    logic [15:0] o_ram_data;
    logic        o_ram_b1_we;
    logic        o_ram_b2_we;
    logic        o_write_page;
    logic        o_display_page;
    logic        i_display_frame_end;
    logic        o_frame_done;
    logic        o_sof_error;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 0 = idle (waiting for SOF), 1 = filling, 2 = waiting for swap
    int          m_state;
    int          m_idx;
    logic        m_wp;
    logic        m_dp;
    logic        e_we1;
    logic        e_we2;
    logic        e_done;
    logic        e_serr;
    logic [10:0] e_addr;
    logic [15:0] e_data;

    always #5 i_clk = ~i_clk;

    frame_buffer_writer dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_pixel_data        (i_pixel_data),
        .i_pixel_valid       (i_pixel_valid),
        .i_pixel_sof         (i_pixel_sof),
        .o_pixel_ready       (o_pixel_ready),
        .o_ram_addr          (o_ram_addr),
        .o_ram_data          (o_ram_data),
        .o_ram_b1_we         (o_ram_b1_we),
        .o_ram_b2_we         (o_ram_b2_we),
        .o_write_page        (o_write_page),
        .o_display_page      (o_display_page),
        .i_display_frame_end (i_display_frame_end),
        .o_frame_done        (o_frame_done),
        .o_sof_error         (o_sof_error)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_idx   = 0;
        m_wp    = 1'b0;
        m_dp    = 1'b1;
        e_we1   = 1'b0;
        e_we2   = 1'b0;
        e_done  = 1'b0;
        e_serr  = 1'b0;
        e_addr  = 11'd0;
        e_data  = 16'h0000;
    endtask

    task automatic check_outputs();
        check_val("b1_we",        32'(o_ram_b1_we),    32'(e_we1));
        check_val("b2_we",        32'(o_ram_b2_we),    32'(e_we2));
        check_val("ram_addr",     32'(o_ram_addr),     32'(e_addr));
        check_val("ram_data",     32'(o_ram_data),     32'(e_data));
        check_val("frame_done",   32'(o_frame_done),   32'(e_done));
        check_val("sof_error",    32'(o_sof_error),    32'(e_serr));
        check_val("write_page",   32'(o_write_page),   32'(m_wp));
        check_val("display_page", 32'(o_display_page), 32'(m_dp));
    endtask

    // One clock cycle: drive at negedge, predict, check registered results after posedge.
    task automatic drive_cycle(input logic v, input logic s, input logic [15:0] d, input logic fe);
        int   w_idx;
        logic wr;
        w_idx = 0;
        wr    = 1'b0;
        @(negedge i_clk);
        i_pixel_valid       = v;
        i_pixel_sof         = s;
        i_pixel_data        = d;
        i_display_frame_end = fe;
        #1;
        check_val("pixel_ready", 32'(o_pixel_ready), 32'(m_state != 2));
        e_done = 1'b0;
        e_serr = 1'b0;
        if (m_state == 2) begin
            if (fe) begin
                m_dp    = m_wp;
                m_wp    = ~m_wp;
                m_state = 0;
            end
        end else if (v) begin
            if (s) begin
                e_serr  = (m_state == 1);
                w_idx   = 0;
                m_idx   = 1;
                m_state = 1;
                wr      = 1'b1;
            end else if (m_state == 1) begin
                w_idx = m_idx;
                wr    = 1'b1;
                if (m_idx == NPIX - 1) begin
                    e_done  = 1'b1;
                    m_state = 2;
                    m_idx   = 0;
                end else begin
                    m_idx++;
                end
            end
        end
        e_we1 = wr && (w_idx < HALF);
        e_we2 = wr && (w_idx >= HALF);
        if (wr) begin
            e_addr = 11'(w_idx % HALF);
            e_data = d;
        end
        @(posedge i_clk);
        #1;
        check_outputs();
    endtask

    initial begin
        logic        v;
        logic        s;
        logic        fe;
        logic [15:0] d;
        int          cyc;
        bit          sent_mid_sof;

        i_rst_n             = 1'b0;
        i_pixel_valid       = 1'b0;
        i_pixel_sof         = 1'b0;
        i_pixel_data        = 16'h0000;
        i_display_frame_end = 1'b0;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        check_outputs();
        check_val("reset_ready", 32'(o_pixel_ready), 32'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Frame 1: back-to-back, data = pixel index.
        drive_cycle(1'b1, 1'b1, 16'd0, 1'b0);
        for (int i = 1; i < NPIX; i++) begin
            drive_cycle(1'b1, 1'b0, 16'(i), 1'b0);
        end
        check_val("frame1_wait_swap", 32'(m_state == 2), 32'd1);
        repeat (3) drive_cycle(1'b1, 1'b0, 16'hAAAA, 1'b0);
        drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1);
        drive_cycle(1'b0, 1'b0, 16'h0000, 1'b0);

        // Frame 2: pre-SOF garbage, SOF 0xF800, valid gaps, mid-frame SOF,
        // frame_end pulses during WRITE and on the last-pixel cycle.
        for (int i = 0; i < 10; i++) begin
            d = 16'($urandom);
            drive_cycle(1'b1, 1'b0, d, 1'b0);
        end
        drive_cycle(1'b1, 1'b1, 16'hF800, 1'b0);
        sent_mid_sof = 1'b0;
        cyc = 0;
        while (m_state != 2 && cyc < 20000) begin
            v  = ($urandom_range(0, 3) != 0);
            s  = 1'b0;
            if (v && !sent_mid_sof && m_state == 1 && m_idx == 100) begin
                s = 1'b1;
                sent_mid_sof = 1'b1;
            end
            fe = ($urandom_range(0, 31) == 0) || (m_idx == 200) ||
                 (m_state == 1 && m_idx == NPIX - 1);
            d  = 16'($urandom);
            drive_cycle(v, s, d, fe);
            cyc++;
        end
        check_val("frame2_complete", 32'(m_state == 2), 32'd1);
        repeat (2) drive_cycle(1'b0, 1'b0, 16'h0000, 1'b0);
        drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1);

        // Frame 3: fill to row 40, then async reset mid-frame.
        drive_cycle(1'b1, 1'b1, 16'h1234, 1'b0);
        while (m_idx < 40 * 64) begin
            d = 16'($urandom);
            drive_cycle(1'b1, 1'b0, d, 1'b0);
        end
        @(negedge i_clk);
        i_pixel_valid = 1'b0;
        i_pixel_sof   = 1'b0;
        i_rst_n       = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check_val("midreset_ready", 32'(o_pixel_ready), 32'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        drive_cycle(1'b1, 1'b0, 16'h5555, 1'b0);
        drive_cycle(1'b1, 1'b1, 16'h07E0, 1'b0);
        drive_cycle(1'b1, 1'b0, 16'h001F, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
